// File: rtl/gpio_pkg.sv
// Shared GPIO defaults for the register file, pad stage and top level.
package gpio_pkg;

   localparam int unsigned GPIO_WIDTH           = 16;
   localparam int unsigned GPIO_SYNC_STAGES     = 2;
   localparam int unsigned GPIO_DEBOUNCE_CYCLES = 4;

   // Width of a counter that must hold 0..cycles; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles == 0) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One pad input: synchroniser chain, stability counter, stable level and edge pulse.
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int unsigned SyncStages     = GPIO_SYNC_STAGES,
   parameter int unsigned DebounceCycles = GPIO_DEBOUNCE_CYCLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pin_i,
   output logic stable_o,
   output logic edge_o
);

   localparam int unsigned CntW = cnt_width(DebounceCycles);

   logic [SyncStages-1:0] sync_q;
   logic                  synced;
   logic                  stable_q, stable_d;
   logic                  edge_q;
   logic [CntW-1:0]       cnt_q, cnt_d;

   assign synced = sync_q[SyncStages-1];

   // Synchroniser chain for the asynchronous pad input.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], pin_i};
      end
   end

   // Accept a new level only after it has been seen for DebounceCycles samples in a row.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (DebounceCycles == 0) begin
         // Bypass: stable mirrors the last sync stage with no extra delay.
         stable_d = sync_q[SyncStages-2];
      end else if (synced != stable_q) begin
         if (cnt_q == CntW'(DebounceCycles - 1)) begin
            stable_d = synced;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Stable level, counter and one-cycle edge pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
         edge_q   <= 1'b0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         edge_q   <= (stable_d != stable_q);
      end
   end

   assign stable_o = stable_q;
   assign edge_o   = edge_q;

endmodule

// File: rtl/gpio_pin_ctrl.sv
// Pad-side GPIO stage: registered pad drive, debounced pin readback and edge interrupts.
module gpio_pin_ctrl
   import gpio_pkg::*;
#(
   parameter int unsigned WIDTH           = GPIO_WIDTH,
   parameter int unsigned SYNC_STAGES     = GPIO_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rf_gpio_datareg,
   input  logic [WIDTH-1:0] rf_gpio_tristate,
   input  logic [WIDTH-1:0] rf_gpio_interrupt_mask,
   input  logic [WIDTH-1:0] irq_clear,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_oe,
   output logic [WIDTH-1:0] ro_gpio_pinstate,
   output logic [WIDTH-1:0] irq_pending,
   output logic             irq
);

   // Edges are ignored until the input pipeline has had time to fill after reset.
   localparam int unsigned WarmCycles = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
   localparam int unsigned WarmW      = $clog2(WarmCycles + 1);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] edge_evt;
   logic [WIDTH-1:0] pin_out_q, pin_oe_q;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             irq_q;
   logic [WarmW-1:0] warm_q;
   logic             warm_done;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      gpio_debounce #(
         .SyncStages     (SYNC_STAGES),
         .DebounceCycles (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk_i    (clk),
         .rst_ni   (reset),
         .pin_i    (pin_in[i]),
         .stable_o (stable[i]),
         .edge_o   (edge_evt[i])
      );
   end

   // Registered pad drive.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pin_out_q <= '0;
         pin_oe_q  <= '0;
      end else begin
         pin_out_q <= rf_gpio_datareg;
         pin_oe_q  <= ~rf_gpio_tristate;
      end
   end

   // Saturating warm-up counter started by reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         warm_q <= '0;
      end else if (!warm_done) begin
         warm_q <= warm_q + 1'b1;
      end
   end

   assign warm_done = (warm_q == WarmW'(WarmCycles));

   // Pending next state: W1C clear, but a same-cycle set takes priority.
   always_comb begin
      pend_d = (pend_q & ~irq_clear)
             | (edge_evt & rf_gpio_interrupt_mask & {WIDTH{warm_done}});
   end

   // Pending bits and the registered interrupt line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         irq_q  <= |(pend_q & rf_gpio_interrupt_mask);
      end
   end

   assign pin_out          = pin_out_q;
   assign pin_oe           = pin_oe_q;
   assign ro_gpio_pinstate = stable;
   assign irq_pending      = pend_q;
   assign irq              = irq_q;

endmodule
